// File: rtl/rob_multi_pkg.sv
// Shared types for the multi-commit reorder buffer: instruction classes,
// the per-entry record and small classification helpers.
package rob_multi_pkg;

    localparam int ROB_DEPTH_BIT_DEF = 4;

    typedef enum logic [1:0] {
        TYPE_RD = 2'd0,
        TYPE_ST = 2'd1,
        TYPE_LD = 2'd2,
        TYPE_BR = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        valid;
        logic        ready;
        rob_type_e   rtype;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pred_pc;
    } rob_entry_t;

    function automatic logic is_mem(input rob_type_e t);
        return (t == TYPE_LD) || (t == TYPE_ST);
    endfunction

    function automatic logic writes_reg(input rob_type_e t);
        return (t == TYPE_RD) || (t == TYPE_LD);
    endfunction

endpackage

// File: rtl/rob_multi_wb_merge.sv
// Operand lookup for one slot: stored ready value first, then the writeback
// channels (lowest channel wins), then a same-cycle ready allocation.
module rob_wb_merge
    import rob_multi_pkg::*;
#(
    parameter int ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
    parameter int WB_PORTS      = 2
) (
    input  logic [ROB_DEPTH_BIT-1:0]          q_id,
    input  logic                              stored_ready,
    input  logic [31:0]                       stored_val,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*ROB_DEPTH_BIT-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]            wb_val,
    input  logic                              alloc_hit,
    input  logic [ROB_DEPTH_BIT-1:0]          alloc_idx,
    input  logic [31:0]                       alloc_val,
    output logic                              q_ready,
    output logic [31:0]                       q_val
);

    logic        wb_hit;
    logic [31:0] wb_sel;

    always_comb begin
        wb_hit = 1'b0;
        wb_sel = '0;
        // Walk downwards so the lowest matching channel is the one kept.
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_id[p*ROB_DEPTH_BIT +: ROB_DEPTH_BIT] == q_id)) begin
                wb_hit = 1'b1;
                wb_sel = wb_val[p*32 +: 32];
            end
        end
    end

    always_comb begin
        q_ready = 1'b0;
        q_val   = '0;
        if (stored_ready) begin
            q_ready = 1'b1;
            q_val   = stored_val;
        end else if (wb_hit) begin
            q_ready = 1'b1;
            q_val   = wb_sel;
        end else if (alloc_hit && (alloc_idx == q_id)) begin
            q_ready = 1'b1;
            q_val   = alloc_val;
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer: one dispatch per cycle, up to two in-order retirements,
// multi-port writeback, bypassed operand lookup and mispredict flush.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
    parameter int WB_PORTS      = 2,
    parameter int COMMIT_W      = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rdy_in,
    input  logic                              alloc_valid,
    input  logic                              alloc_ready,
    input  logic [31:0]                       alloc_value,
    input  logic [4:0]                        alloc_rd,
    input  rob_type_e                         alloc_type,
    input  logic [31:0]                       alloc_pc,
    input  logic [31:0]                       alloc_pred_pc,
    output logic [ROB_DEPTH_BIT-1:0]          alloc_id,
    output logic                              full_out,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*ROB_DEPTH_BIT-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]            wb_val,
    input  logic [2*ROB_DEPTH_BIT-1:0]        q_id,
    output logic [1:0]                        q_ready,
    output logic [63:0]                       q_val,
    output logic [COMMIT_W-1:0]               cm_valid,
    output logic [COMMIT_W*5-1:0]             cm_rd,
    output logic [COMMIT_W*32-1:0]            cm_val,
    output logic [COMMIT_W*ROB_DEPTH_BIT-1:0] cm_id,
    output logic                              head_mem,
    output logic [ROB_DEPTH_BIT-1:0]          head_id,
    output logic [1:0]                        commit_cnt,
    output logic                              flush_out,
    output logic [31:0]                       pc_fact
);

    localparam int DEPTH = 1 << ROB_DEPTH_BIT;

    typedef logic [ROB_DEPTH_BIT-1:0] idx_t;
    typedef logic [ROB_DEPTH_BIT:0]   cnt_t;

    rob_entry_t  entry_q [DEPTH];
    rob_entry_t  entry_d [DEPTH];
    idx_t        head_q, head_d, tail_q, tail_d;
    cnt_t        count_q, count_d;
    logic        flush_q, flush_d;
    logic [31:0] pc_fact_q, pc_fact_d;

    idx_t        h1;
    idx_t        slot_idx [2];
    rob_entry_t  e0;
    logic        c0, c1, mis0, alloc_fire;
    logic [1:0]  slot_cm;
    logic        unused_pc;

    assign unused_pc = ^alloc_pc;

    assign h1          = head_q + 1'b1;
    assign slot_idx[0] = head_q;
    assign slot_idx[1] = h1;
    assign e0          = entry_q[head_q];

    // count never exceeds DEPTH, so its top bit alone marks a full buffer.
    assign full_out   = count_q[ROB_DEPTH_BIT] || flush_q;
    assign alloc_fire = rdy_in && alloc_valid && !full_out;

    assign c0   = rdy_in && e0.valid && e0.ready;
    assign mis0 = c0 && (e0.rtype == TYPE_BR) && (e0.value != e0.pred_pc);
    assign c1   = (COMMIT_W == 2) && c0 && (e0.rtype != TYPE_BR)
                  && entry_q[h1].valid && entry_q[h1].ready
                  && !(is_mem(e0.rtype) && is_mem(entry_q[h1].rtype));

    assign commit_cnt = c1 ? 2'd2 : (c0 ? 2'd1 : 2'd0);
    assign slot_cm[0] = c0 && writes_reg(e0.rtype);
    assign slot_cm[1] = c1 && writes_reg(entry_q[h1].rtype);

    assign alloc_id  = tail_q;
    assign head_id   = head_q;
    assign head_mem  = e0.valid && is_mem(e0.rtype);
    assign flush_out = flush_q;
    assign pc_fact   = pc_fact_q;

    always_comb begin
        cm_valid = '0;
        cm_rd    = '0;
        cm_val   = '0;
        cm_id    = '0;
        for (int s = 0; s < COMMIT_W; s++) begin
            if (slot_cm[s]) begin
                cm_valid[s]                                = 1'b1;
                cm_rd[s*5 +: 5]                            = entry_q[slot_idx[s]].rd;
                cm_val[s*32 +: 32]                         = entry_q[slot_idx[s]].value;
                cm_id[s*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]    = slot_idx[s];
            end
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_lookup
        idx_t qi;
        assign qi = q_id[s*ROB_DEPTH_BIT +: ROB_DEPTH_BIT];

        rob_wb_merge #(
            .ROB_DEPTH_BIT (ROB_DEPTH_BIT),
            .WB_PORTS      (WB_PORTS)
        ) u_merge (
            .q_id         (qi),
            .stored_ready (entry_q[qi].ready),
            .stored_val   (entry_q[qi].value),
            .wb_valid     (wb_valid),
            .wb_id        (wb_id),
            .wb_val       (wb_val),
            .alloc_hit    (alloc_fire && alloc_ready),
            .alloc_idx    (tail_q),
            .alloc_val    (alloc_value),
            .q_ready      (q_ready[s]),
            .q_val        (q_val[s*32 +: 32])
        );
    end

    always_comb begin
        entry_d   = entry_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        flush_d   = 1'b0;
        pc_fact_d = pc_fact_q;
        if (!rdy_in) begin
            flush_d = flush_q;
        end else if (mis0) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
                entry_d[i].ready = 1'b0;
            end
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            flush_d   = 1'b1;
            pc_fact_d = e0.value;
        end else begin
            if (!flush_q) begin
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_valid[p] && entry_q[wb_id[p*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].valid) begin
                        entry_d[wb_id[p*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].ready = 1'b1;
                        entry_d[wb_id[p*ROB_DEPTH_BIT +: ROB_DEPTH_BIT]].value = wb_val[p*32 +: 32];
                    end
                end
            end
            if (c0) begin
                entry_d[head_q].valid = 1'b0;
                entry_d[head_q].ready = 1'b0;
            end
            if (c1) begin
                entry_d[h1].valid = 1'b0;
                entry_d[h1].ready = 1'b0;
            end
            head_d = head_q + idx_t'(commit_cnt);
            if (alloc_fire) begin
                entry_d[tail_q] = '{valid: 1'b1, ready: alloc_ready, rtype: alloc_type,
                                    rd: alloc_rd, value: alloc_value, pred_pc: alloc_pred_pc};
                tail_d = tail_q + 1'b1;
            end
            count_d = count_q + cnt_t'(alloc_fire) - cnt_t'(commit_cnt);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            flush_q   <= 1'b0;
            pc_fact_q <= '0;
        end else begin
            entry_q   <= entry_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            flush_q   <= flush_d;
            pc_fact_q <= pc_fact_d;
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in, alloc_valid, alloc_ready;
    logic [31:0] alloc_value, alloc_pc, alloc_pred_pc;
    logic [4:0]  alloc_rd;
    rob_type_e   alloc_type;
    logic [3:0]  alloc_id;
    logic        full_out;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_id;
    logic [63:0] wb_val;
    logic [7:0]  q_id;
    logic [1:0]  q_ready;
    logic [63:0] q_val;
    logic [1:0]  cm_valid;
    logic [9:0]  cm_rd;
    logic [63:0] cm_val;
    logic [7:0]  cm_id;
    logic        head_mem;
    logic [3:0]  head_id;
    logic [1:0]  commit_cnt;
    logic        flush_out;
    logic [31:0] pc_fact;

    rob_multi #(.ROB_DEPTH_BIT(4), .WB_PORTS(2), .COMMIT_W(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_value(alloc_value),
        .alloc_rd(alloc_rd), .alloc_type(alloc_type), .alloc_pc(alloc_pc),
        .alloc_pred_pc(alloc_pred_pc), .alloc_id(alloc_id), .full_out(full_out),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .q_id(q_id), .q_ready(q_ready), .q_val(q_val),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_id(cm_id),
        .head_mem(head_mem), .head_id(head_id), .commit_cnt(commit_cnt),
        .flush_out(flush_out), .pc_fact(pc_fact)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: in-flight instructions oldest first; entry k lives at id (mhead+k)%DEPTH.
    typedef struct {
        logic        ready;
        logic [31:0] val;
        logic [4:0]  rd;
        rob_type_e   typ;
        logic [31:0] pred;
    } ment_t;

    ment_t       mq[$];
    int          mhead = 0;
    logic        mflush = 1'b0;
    logic [31:0] mpcf = '0;
    int          m_n;
    logic        m_mis, m_fire;

    task automatic model_reset();
        mq.delete();
        mhead  = 0;
        mflush = 1'b0;
        mpcf   = '0;
    endtask

    task automatic check_outputs();
        int          sz = mq.size();
        int          tail = (mhead + sz) % DEPTH;
        logic        efull = (sz == DEPTH) || mflush;
        logic [1:0]  ecv = '0;
        logic [9:0]  erd = '0;
        logic [63:0] ecval = '0;
        logic [7:0]  ecid = '0;
        logic [1:0]  eqr = '0;
        logic [63:0] eqv = '0;
        logic        ehm = (sz > 0) && (mq[0].typ inside {TYPE_LD, TYPE_ST});
        m_fire = rdy_in && alloc_valid && !efull;
        m_n    = 0;
        m_mis  = 1'b0;
        if (rdy_in && sz > 0 && mq[0].ready) begin
            m_n = 1;
            if (mq[0].typ == TYPE_BR) m_mis = (mq[0].val != mq[0].pred);
            else if (sz > 1 && mq[1].ready &&
                     !((mq[0].typ inside {TYPE_LD, TYPE_ST}) && (mq[1].typ inside {TYPE_LD, TYPE_ST})))
                m_n = 2;
        end
        for (int s = 0; s < m_n; s++) begin
            if (mq[s].typ inside {TYPE_RD, TYPE_LD}) begin
                ecv[s]           = 1'b1;
                erd[s*5 +: 5]    = mq[s].rd;
                ecval[s*32 +: 32] = mq[s].val;
                ecid[s*4 +: 4]   = 4'((mhead + s) % DEPTH);
            end
        end
        for (int s = 0; s < 2; s++) begin
            int qi = int'(q_id[s*4 +: 4]);
            int k  = (qi - mhead + DEPTH) % DEPTH;
            if (k < sz && mq[k].ready) begin
                eqr[s] = 1'b1;
                eqv[s*32 +: 32] = mq[k].val;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (!eqr[s] && wb_valid[p] && int'(wb_id[p*4 +: 4]) == qi) begin
                        eqr[s] = 1'b1;
                        eqv[s*32 +: 32] = wb_val[p*32 +: 32];
                    end
                end
                if (!eqr[s] && m_fire && alloc_ready && qi == tail) begin
                    eqr[s] = 1'b1;
                    eqv[s*32 +: 32] = alloc_value;
                end
            end
        end
        chk("full_out", full_out, efull);
        chk("alloc_id", alloc_id, tail);
        chk("head_id", head_id, mhead);
        chk("head_mem", head_mem, ehm);
        chk("commit_cnt", commit_cnt, m_n);
        chk("cm_valid", cm_valid, ecv);
        chk("cm_rd", cm_rd, erd);
        chk("cm_val", cm_val, ecval);
        chk("cm_id", cm_id, ecid);
        chk("q_ready", q_ready, eqr);
        chk("q_val", q_val, eqv);
        chk("flush_out", flush_out, mflush);
        chk("pc_fact", pc_fact, mpcf);
    endtask

    task automatic model_step();
        ment_t e;
        if (!rdy_in) return;
        if (m_mis) begin
            mpcf = mq[0].val;
            mq.delete();
            mhead  = 0;
            mflush = 1'b1;
            return;
        end
        if (!mflush) begin
            for (int k = 0; k < mq.size(); k++) begin
                int   id = (mhead + k) % DEPTH;
                logic hit = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (!hit && wb_valid[p] && int'(wb_id[p*4 +: 4]) == id) begin
                        hit     = 1'b1;
                        e       = mq[k];
                        e.ready = 1'b1;
                        e.val   = wb_val[p*32 +: 32];
                        mq[k]   = e;
                    end
                end
            end
        end
        mflush = 1'b0;
        repeat (m_n) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % DEPTH;
        end
        if (m_fire) begin
            e = '{ready: alloc_ready, val: alloc_value, rd: alloc_rd, typ: alloc_type, pred: alloc_pred_pc};
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        check_outputs();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; alloc_valid = 1'b0; alloc_ready = 1'b0; alloc_value = '0;
        alloc_rd = '0; alloc_type = TYPE_RD; alloc_pc = '0; alloc_pred_pc = '0;
        wb_valid = '0; wb_id = '0; wb_val = '0; q_id = '0;
    endtask

    task automatic do_alloc(input rob_type_e t, input logic [4:0] rd, input logic r,
                            input logic [31:0] v, input logic [31:0] pred);
        alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd; alloc_ready = r;
        alloc_value = v; alloc_pred_pc = pred; alloc_pc = $urandom;
    endtask

    task automatic fill_and_wrap();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); do_alloc(TYPE_RD, 5'(i), 1'b0, 32'h0, 32'h0); tick();
        end
        idle(); #1;
        chk("fill_full", full_out, 1'b1);
        chk("fill_alloc_id", alloc_id, 4'd2);
        for (int t = 0; t < 24; t++) begin
            int off = (t == 0) ? 0 : 2;
            idle(); do_alloc(TYPE_RD, 5'(t + 1), 1'b0, 32'h0, 32'h0);
            wb_valid = 2'b11;
            wb_id    = {4'((mhead + off + 1) % DEPTH), 4'((mhead + off) % DEPTH)};
            wb_val   = {32'($urandom), 32'($urandom)};
            tick();
        end
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6) begin
                rob_type_e   t    = rob_type_e'($urandom_range(0, 3));
                logic [31:0] pred = $urandom;
                logic        r    = ($urandom_range(0, 2) == 0);
                logic [31:0] v    = (t == TYPE_BR && $urandom_range(0, 9) != 0) ? pred : 32'($urandom);
                do_alloc(t, 5'($urandom), r, v, pred);
            end
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int          off = $urandom_range(0, DEPTH - 1);
                    logic [31:0] v   = $urandom;
                    if (off < mq.size() && mq[off].typ == TYPE_BR && $urandom_range(0, 9) != 0)
                        v = mq[off].pred;
                    wb_valid[p]        = 1'b1;
                    wb_id[p*4 +: 4]    = 4'((mhead + off) % DEPTH);
                    wb_val[p*32 +: 32] = v;
                end
            end
            q_id = 8'($urandom);
            tick();
        end
    endtask

    task automatic reset_mid_run();
        for (int i = 0; i < 3; i++) begin
            idle(); do_alloc(TYPE_RD, 5'(i), 1'b1, 32'(i), 32'h0); tick();
        end
        for (int i = 0; i < 5; i++) begin
            idle(); do_alloc(TYPE_LD, 5'(i), 1'b0, 32'h0, 32'h0); tick();
        end
        idle();
        #2 rst_n_in = 1'b0;
        #1;
        model_reset();
        chk("arst_full", full_out, 1'b0);
        chk("arst_cm_valid", cm_valid, 2'b00);
        chk("arst_flush", flush_out, 1'b0);
        chk("arst_head_id", head_id, 4'd0);
        chk("arst_alloc_id", alloc_id, 4'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_full", full_out, 1'b0);
        chk("rst_q_ready", q_ready, 2'b00);
        chk("rst_flush", flush_out, 1'b0);
        chk("rst_pc_fact", pc_fact, 32'h0);
        chk("rst_alloc_id", alloc_id, 4'd0);
        rst_n_in = 1'b1;

        // Dual commit
        idle(); do_alloc(TYPE_RD, 5'd3, 1'b0, 32'h0, 32'h0); tick();
        idle(); do_alloc(TYPE_RD, 5'd4, 1'b0, 32'h0, 32'h0); tick();
        idle(); wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_val = {32'h22, 32'h11}; tick();
        idle(); #1;
        chk("dual_cm_valid", cm_valid, 2'b11);
        chk("dual_cm_rd", cm_rd, {5'd4, 5'd3});
        chk("dual_cm_val", cm_val, {32'h22, 32'h11});
        chk("dual_commit_cnt", commit_cnt, 2'd2);
        tick();

        // Mispredict at head with a ready instruction behind it
        idle(); do_alloc(TYPE_BR, 5'd0, 1'b0, 32'h0, 32'h100); tick();
        idle(); do_alloc(TYPE_RD, 5'd5, 1'b1, 32'h55, 32'h0);
        wb_valid = 2'b01; wb_id = {4'd0, 4'd2}; wb_val = {32'h0, 32'h200}; tick();
        idle(); #1;
        chk("mis_commit_cnt", commit_cnt, 2'd1);
        chk("mis_cm_valid", cm_valid, 2'b00);
        tick();
        idle(); #1;
        chk("mis_flush", flush_out, 1'b1);
        chk("mis_pc_fact", pc_fact, 32'h200);
        chk("mis_full", full_out, 1'b1);
        tick();
        idle(); #1;
        chk("post_flush", flush_out, 1'b0);
        chk("post_full", full_out, 1'b0);
        chk("post_head", head_id, 4'd0);

        // Load followed by store retire one per cycle
        idle(); do_alloc(TYPE_LD, 5'd6, 1'b0, 32'h0, 32'h0); tick();
        idle(); do_alloc(TYPE_ST, 5'd0, 1'b0, 32'h0, 32'h0); tick();
        idle(); wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_val = {32'h77, 32'h66}; tick();
        idle(); #1;
        chk("mem_cnt0", commit_cnt, 2'd1);
        chk("mem_cm_rd0", cm_rd[4:0], 5'd6);
        tick();
        idle(); #1;
        chk("mem_cnt1", commit_cnt, 2'd1);
        chk("mem_cm_valid1", cm_valid, 2'b00);
        tick();

        // Writeback bypass and channel priority
        idle(); q_id = 8'h07; wb_valid = 2'b10; wb_id = {4'd7, 4'd0}; wb_val = {32'hABCD, 32'h0};
        #1;
        chk("byp_ready", q_ready[0], 1'b1);
        chk("byp_val", q_val[31:0], 32'hABCD);
        wb_valid = 2'b11; wb_id = {4'd7, 4'd7}; wb_val = {32'hABCD, 32'h1};
        #1;
        chk("byp_prio", q_val[31:0], 32'h1);
        tick();

        fill_and_wrap();
        random_phase(3000);
        reset_mid_run();
        random_phase(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
